// File: rtl/timer_control_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown timer.
package timer_control_pkg;

   localparam int unsigned DigitW = 4;
   localparam logic [DigitW-1:0] BcdUnitsMax = 4'd9;
   localparam logic [DigitW-1:0] BcdTensMax  = 4'd5;

   // Bit positions in the packed button vector
   localparam int unsigned BtnSec   = 0;
   localparam int unsigned BtnMin   = 1;
   localparam int unsigned BtnStart = 2;
   localparam int unsigned BtnClear = 3;
   localparam int unsigned NumBtn   = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StAlarm = 2'd3
   } state_e;

   typedef struct packed {
      logic [DigitW-1:0] min_tens;
      logic [DigitW-1:0] min_units;
      logic [DigitW-1:0] sec_tens;
      logic [DigitW-1:0] sec_units;
   } mmss_t;

   // Modulo-60 BCD increment of a tens/units pair, 59 wraps to 00
   function automatic logic [2*DigitW-1:0] bcd60_inc(input logic [DigitW-1:0] tens,
                                                     input logic [DigitW-1:0] units);
      logic [DigitW-1:0] t;
      logic [DigitW-1:0] u;
      t = tens;
      u = units + 4'd1;
      if (units == BcdUnitsMax) begin
         u = '0;
         t = (tens == BcdTensMax) ? '0 : tens + 4'd1;
      end
      return {t, u};
   endfunction

   function automatic mmss_t mmss_dec(input mmss_t t);
      mmss_t r;
      r = t;
      if (t.sec_units != '0) begin
         r.sec_units = t.sec_units - 4'd1;
      end else begin
         r.sec_units = BcdUnitsMax;
         if (t.sec_tens != '0) begin
            r.sec_tens = t.sec_tens - 4'd1;
         end else begin
            r.sec_tens = BcdTensMax;
            if (t.min_units != '0) begin
               r.min_units = t.min_units - 4'd1;
            end else begin
               r.min_units = BcdUnitsMax;
               r.min_tens  = t.min_tens - 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/timer_control_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
module timer_control_tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CntW = $clog2(TICK_DIV);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = en & (cnt_q == CntW'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/timer_control.sv
// MM:SS countdown timer: button edge detect, run/pause/alarm FSM, BCD time keeping.
module timer_control
   import timer_control_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 100_000_000,
   parameter int unsigned ALARM_SEC = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_start,
   input  logic              btn_min,
   input  logic              btn_sec,
   input  logic              btn_clear,
   output logic [DigitW-1:0] bcd0,
   output logic [DigitW-1:0] bcd1,
   output logic [DigitW-1:0] bcd2,
   output logic [DigitW-1:0] bcd3,
   output logic              running,
   output logic              paused,
   output logic              alarm
);

   localparam int unsigned AlarmW = $clog2(ALARM_SEC + 1);

   logic [NumBtn-1:0] btn_sync_q, btn_hist_q, press;
   state_e            state_q, state_d;
   mmss_t             time_q, time_d;
   logic [AlarmW-1:0] alarm_cnt_q, alarm_cnt_d;
   logic              tick;
   logic              running_q, paused_q, alarm_q;

   assign press = btn_sync_q & ~btn_hist_q;

   timer_control_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    ((state_q == StRun) || (state_q == StAlarm)),
      .clr   (state_q == StIdle),
      .tick  (tick)
   );

   always_comb begin
      state_d     = state_q;
      time_d      = time_q;
      alarm_cnt_d = '0;
      if (press[BtnClear]) begin
         state_d = StIdle;
         time_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // A start press consumes the cycle even when ignored at 00:00
               if (press[BtnStart]) begin
                  if (time_q != '0) state_d = StRun;
               end else begin
                  if (press[BtnMin]) begin
                     {time_d.min_tens, time_d.min_units} = bcd60_inc(time_q.min_tens,
                                                                     time_q.min_units);
                  end
                  if (press[BtnSec]) begin
                     {time_d.sec_tens, time_d.sec_units} = bcd60_inc(time_q.sec_tens,
                                                                     time_q.sec_units);
                  end
               end
            end
            StRun: begin
               if (tick && (time_q != '0)) begin
                  time_d = mmss_dec(time_q);
                  if (time_q == mmss_t'(16'h0001)) state_d = StAlarm;
                  else if (press[BtnStart])        state_d = StPause;
               end else if (press[BtnStart]) begin
                  state_d = StPause;
               end
            end
            StPause: begin
               if (press[BtnStart]) state_d = StRun;
            end
            StAlarm: begin
               alarm_cnt_d = alarm_cnt_q;
               if (press[BtnStart]) begin
                  state_d = StIdle;
               end else if (tick) begin
                  if (alarm_cnt_q == AlarmW'(ALARM_SEC - 1)) state_d = StIdle;
                  else                                        alarm_cnt_d = alarm_cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_sync_q  <= '0;
         btn_hist_q  <= '0;
         state_q     <= StIdle;
         time_q      <= '0;
         alarm_cnt_q <= '0;
         running_q   <= 1'b0;
         paused_q    <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         btn_sync_q  <= {btn_clear, btn_start, btn_min, btn_sec};
         btn_hist_q  <= btn_sync_q;
         state_q     <= state_d;
         time_q      <= time_d;
         alarm_cnt_q <= alarm_cnt_d;
         running_q   <= (state_d == StRun);
         paused_q    <= (state_d == StPause);
         alarm_q     <= (state_d == StAlarm);
      end
   end

   assign bcd0    = time_q.min_tens;
   assign bcd1    = time_q.min_units;
   assign bcd2    = time_q.sec_tens;
   assign bcd3    = time_q.sec_units;
   assign running = running_q;
   assign paused  = paused_q;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_timer_control.sv
// Randomised and directed bench for timer_control against a seconds-count reference model.
module tb_timer_control;

   localparam int unsigned TickDiv  = 4;
   localparam int unsigned AlarmSec = 2;

   localparam int SIdle  = 0;
   localparam int SRun   = 1;
   localparam int SPause = 2;
   localparam int SAlarm = 3;

   // btns = {clear, start, min, sec}
   localparam int BClr = 3;
   localparam int BSt  = 2;
   localparam int BMin = 1;
   localparam int BSec = 0;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btns = '0;
   logic [3:0] bcd0, bcd1, bcd2, bcd3;
   logic       running, paused, alarm;

   int n_vec = 0;
   int n_err = 0;

   int         m_st, m_min, m_sec, m_pc, m_ac;
   logic [3:0] m_p1, m_p2;

   timer_control #(
      .TICK_DIV  (TickDiv),
      .ALARM_SEC (AlarmSec)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_start (btns[BSt]),
      .btn_min   (btns[BMin]),
      .btn_sec   (btns[BSec]),
      .btn_clear (btns[BClr]),
      .bcd0      (bcd0),
      .bcd1      (bcd1),
      .bcd2      (bcd2),
      .bcd3      (bcd3),
      .running   (running),
      .paused    (paused),
      .alarm     (alarm)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [18:0] dut_vec();
      return {bcd0, bcd1, bcd2, bcd3, running, paused, alarm};
   endfunction

   function automatic logic [15:0] dut_time();
      return {bcd0, bcd1, bcd2, bcd3};
   endfunction

   function automatic logic [18:0] exp_vec();
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
              m_st == SRun, m_st == SPause, m_st == SAlarm};
   endfunction

   task automatic model_reset();
      m_st = SIdle; m_min = 0; m_sec = 0; m_pc = 0; m_ac = 0;
      m_p1 = '0; m_p2 = '0;
   endtask

   // One clock of the reference: a press is a level high now that was low the sample before
   task automatic model_step();
      logic [3:0] pr;
      bit         tick;
      int         tot;
      pr   = m_p1 & ~m_p2;
      m_p2 = m_p1;
      m_p1 = btns;
      tick = (m_st == SRun || m_st == SAlarm) && (m_pc == TickDiv - 1);
      if (m_st == SIdle)       m_pc = 0;
      else if (m_st != SPause) m_pc = (m_pc + 1) % TickDiv;
      tot = m_min * 60 + m_sec;
      if (pr[BClr]) begin
         m_st = SIdle;
         tot  = 0;
      end else begin
         case (m_st)
            SIdle: begin
               if (pr[BSt]) begin
                  if (tot != 0) m_st = SRun;
               end else begin
                  if (pr[BMin]) tot = ((m_min + 1) % 60) * 60 + m_sec;
                  if (pr[BSec]) tot = (tot / 60) * 60 + (m_sec + 1) % 60;
               end
            end
            SRun: begin
               if (tick) begin
                  tot = tot - 1;
                  if (tot == 0) begin
                     m_st = SAlarm;
                     m_ac = 0;
                  end else if (pr[BSt]) m_st = SPause;
               end else if (pr[BSt]) m_st = SPause;
            end
            SPause: if (pr[BSt]) m_st = SRun;
            default: begin
               if (pr[BSt]) m_st = SIdle;
               else if (tick) begin
                  m_ac++;
                  if (m_ac == AlarmSec) m_st = SIdle;
               end
            end
         endcase
      end
      m_min = tot / 60;
      m_sec = tot % 60;
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!reset) model_reset();
         else        model_step();
         @(negedge clk);
         check_eq("cycle", 32'(dut_vec()), 32'(exp_vec()));
      end
   endtask

   task automatic press(input int b, input int times);
      for (int i = 0; i < times; i++) begin
         btns[b] = 1'b1;
         cycle(2);
         btns[b] = 1'b0;
         cycle(2);
      end
   endtask

   initial begin
      int acyc;
      logic [15:0] frozen;
      model_reset();
      @(negedge clk);
      cycle(2);
      reset = 1'b1;
      cycle(2);
      check_eq("reset_state", 32'(dut_vec()), 32'h0);

      // 1: asynchronous reset mid-countdown
      press(BMin, 12);
      press(BSec, 34);
      check_eq("t1_set", 32'(dut_time()), 32'h1234);
      press(BSt, 1);
      cycle(7);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_eq("t1_async", 32'(dut_vec()), 32'h0);
      model_reset();
      @(negedge clk);
      cycle(2);
      reset = 1'b1;
      cycle(3);
      check_eq("t1_after", 32'(dut_vec()), 32'h0);

      // 2: seconds wrap without carry
      press(BMin, 3);
      press(BSec, 61);
      check_eq("t2_display", 32'(dut_time()), 32'h0301);
      press(BClr, 1);

      // 3: start latency and first tick
      press(BMin, 1);
      btns[BSt] = 1'b1;
      cycle(1);
      check_eq("t3_not_yet", 32'(running), 32'h0);
      cycle(1);
      check_eq("t3_run_lat", 32'(running), 32'h1);
      btns[BSt] = 1'b0;
      cycle(3);
      check_eq("t3_pre_tick", 32'(dut_time()), 32'h0100);
      cycle(1);
      check_eq("t3_tick1", 32'(dut_time()), 32'h0059);
      cycle(TickDiv);
      check_eq("t3_tick2", 32'(dut_time()), 32'h0058);
      press(BClr, 1);

      // 4: alarm at 00:00 and its duration
      press(BSec, 2);
      press(BSt, 1);
      acyc = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(1);
         if (alarm) acyc++;
         else if (acyc > 0) break;
      end
      check_eq("t4_alarm_len", 32'(acyc), 32'(AlarmSec * TickDiv));
      check_eq("t4_idle", 32'(dut_vec()), 32'h0);

      // 5: pause freezes value and prescaler
      press(BSec, 30);
      press(BSt, 1);
      cycle(10);
      btns[BSt] = 1'b1;
      cycle(2);
      check_eq("t5_paused", 32'(paused), 32'h1);
      frozen = dut_time();
      btns[BSt] = 1'b0;
      press(BSec, 2);
      cycle(25);
      check_eq("t5_frozen", 32'(dut_time()), 32'(frozen));
      press(BSt, 1);
      cycle(3 * TickDiv);
      check_eq("t5_resumed", 32'(running), 32'h1);
      press(BClr, 1);

      // 6: start at zero, start+clear together, held button
      press(BSt, 1);
      check_eq("t6_zero_start", 32'(running), 32'h0);
      press(BSec, 5);
      press(BSt, 1);
      cycle(3);
      btns[BSt]  = 1'b1;
      btns[BClr] = 1'b1;
      cycle(2);
      check_eq("t6_clr_wins", 32'(dut_vec()), 32'h0);
      btns = '0;
      cycle(2);
      btns[BMin] = 1'b1;
      cycle(20);
      btns[BMin] = 1'b0;
      cycle(2);
      check_eq("t6_held", 32'(dut_time()), 32'h0100);
      press(BClr, 1);

      // Random button activity
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0)   btns[BSec] = ~btns[BSec];
         if ($urandom_range(0, 39) == 0)  btns[BMin] = ~btns[BMin];
         if ($urandom_range(0, 29) == 0)  btns[BSt]  = ~btns[BSt];
         if ($urandom_range(0, 299) == 0) btns[BClr] = ~btns[BClr];
         cycle(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
